// File: rtl/hsl_track_pkg.sv
// Shared definitions for the HSL colour tracker: widths, hue span,
// controller state type and the threshold bundle used by the window compare.
package hsl_track_pkg;

    localparam int COMP_W  = 10;
    localparam int COUNT_W = 19;
    localparam int SUM_W   = 28;

    // Hue runs 0..767; anything at or above this is folded back to 0
    localparam logic [COMP_W-1:0] HUE_SPAN = 10'd768;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        REPORT = 2'd2
    } trackState_t;

    typedef struct packed {
        logic [COMP_W-1:0] hueLo;
        logic [COMP_W-1:0] hueHi;
        logic [COMP_W-1:0] satMin;
        logic [COMP_W-1:0] lightMin;
        logic [COMP_W-1:0] lightMax;
    } thresh_t;

endpackage

// File: rtl/hsl_window_cmp.sv
// Combinational HSL window test: folds out-of-range hue to 0, supports a hue
// window that wraps through 767/0, and applies inclusive sat/light limits.
module hsl_window_cmp
    import hsl_track_pkg::*;
(
    input  logic [COMP_W-1:0] hue,
    input  logic [COMP_W-1:0] sat,
    input  logic [COMP_W-1:0] light,
    input  thresh_t           thresh,
    output logic              match
);

    logic [COMP_W-1:0] hueNorm;
    logic              hueOk;
    logic              satOk;
    logic              lightOk;

    // Decide hue membership (plain or wrapped window) and combine with sat/light limits
    always_comb begin
        hueNorm = (hue >= HUE_SPAN) ? '0 : hue;
        if (thresh.hueLo <= thresh.hueHi) begin
            hueOk = (hueNorm >= thresh.hueLo) && (hueNorm <= thresh.hueHi);
        end else begin
            hueOk = (hueNorm >= thresh.hueLo) || (hueNorm <= thresh.hueHi);
        end
        satOk   = (sat >= thresh.satMin);
        lightOk = (light >= thresh.lightMin) && (light <= thresh.lightMax);
        match   = hueOk && satOk && lightOk;
    end

endmodule

// File: rtl/hsl_color_tracker.sv
// HSL colour tracker: per-pixel window mask plus per-frame bounding box,
// match count and (optionally) coordinate sums, reported once per full frame.
// Define HSL_TRACK_CENTROID_EN to build the coordinate-sum accumulators;
// without it oSumX/oSumY are tied to 0.
module hsl_color_tracker
    import hsl_track_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
)(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               iValid,
    input  logic               iSOF,
    input  logic [COMP_W-1:0]  iHue,
    input  logic [COMP_W-1:0]  iSat,
    input  logic [COMP_W-1:0]  iLight,
    input  logic [COMP_W-1:0]  iHueLo,
    input  logic [COMP_W-1:0]  iHueHi,
    input  logic [COMP_W-1:0]  iSatMin,
    input  logic [COMP_W-1:0]  iLightMin,
    input  logic [COMP_W-1:0]  iLightMax,
    output logic               oValid,
    output logic               oMask,
    output logic [COMP_W-1:0]  oXMin,
    output logic [COMP_W-1:0]  oXMax,
    output logic [COMP_W-1:0]  oYMin,
    output logic [COMP_W-1:0]  oYMax,
    output logic [COUNT_W-1:0] oCount,
    output logic               oFound,
    output logic               oFrameDone,
    output logic [SUM_W-1:0]   oSumX,
    output logic [SUM_W-1:0]   oSumY
);

    localparam logic [COMP_W-1:0] LAST_X = COMP_W'(IMG_W - 1);
    localparam logic [COMP_W-1:0] LAST_Y = COMP_W'(IMG_H - 1);

    trackState_t        state;
    trackState_t        stateNext;
    thresh_t            threshIn;
    thresh_t            shadow;
    thresh_t            threshEff;

    logic               sofPix;
    logic               framePix;
    logic               lastPix;
    logic               pixMatch;
    logic [COMP_W-1:0]  xCnt;
    logic [COMP_W-1:0]  yCnt;
    logic [COMP_W-1:0]  pixX;
    logic [COMP_W-1:0]  pixY;

    logic [COMP_W-1:0]  accXMin;
    logic [COMP_W-1:0]  accXMax;
    logic [COMP_W-1:0]  accYMin;
    logic [COMP_W-1:0]  accYMax;
    logic [COUNT_W-1:0] accCount;
    logic [COMP_W-1:0]  nextXMin;
    logic [COMP_W-1:0]  nextXMax;
    logic [COMP_W-1:0]  nextYMin;
    logic [COMP_W-1:0]  nextYMax;
    logic [COUNT_W-1:0] nextCount;
    logic               accAny;

    // Classify the incoming pixel: frame start, part of a frame, its coordinates and thresholds
    always_comb begin
        threshIn  = '{hueLo: iHueLo, hueHi: iHueHi, satMin: iSatMin,
                      lightMin: iLightMin, lightMax: iLightMax};
        sofPix    = iValid && iSOF;
        framePix  = iValid && (iSOF || (state == ACTIVE));
        pixX      = sofPix ? '0 : xCnt;
        pixY      = sofPix ? '0 : yCnt;
        threshEff = sofPix ? threshIn : shadow;
        lastPix   = framePix && (pixX == LAST_X) && (pixY == LAST_Y);
        accAny    = (accCount != '0);
    end

    hsl_window_cmp uCmp (
        .hue    (iHue),
        .sat    (iSat),
        .light  (iLight),
        .thresh (threshEff),
        .match  (pixMatch)
    );

    // Controller state register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic; the frame's final pixel always leads to the report cycle
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (sofPix) stateNext = ACTIVE;
            ACTIVE:  stateNext = ACTIVE;
            REPORT:  stateNext = sofPix ? ACTIVE : IDLE;
            default: stateNext = IDLE;
        endcase
        if (lastPix) begin
            stateNext = REPORT;
        end
    end

    // Thresholds are captured at frame start so mid-frame changes wait for the next frame
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            shadow <= '0;
        end else if (sofPix) begin
            shadow <= threshIn;
        end
    end

    // Raster position of the next expected pixel within the frame
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            xCnt <= '0;
            yCnt <= '0;
        end else if (framePix) begin
            if (pixX == LAST_X) begin
                xCnt <= '0;
                yCnt <= (pixY == LAST_Y) ? '0 : pixY + 1'b1;
            end else begin
                xCnt <= pixX + 1'b1;
                yCnt <= pixY;
            end
        end
    end

    // Accumulator update; a frame start restarts from the empty-box values
    always_comb begin
        nextXMin  = sofPix ? '1 : accXMin;
        nextXMax  = sofPix ? '0 : accXMax;
        nextYMin  = sofPix ? '1 : accYMin;
        nextYMax  = sofPix ? '0 : accYMax;
        nextCount = sofPix ? '0 : accCount;
        if (pixMatch) begin
            if (pixX < nextXMin) nextXMin = pixX;
            if (pixX > nextXMax) nextXMax = pixX;
            if (pixY < nextYMin) nextYMin = pixY;
            if (pixY > nextYMax) nextYMax = pixY;
            nextCount = nextCount + 1'b1;
        end
    end

    // Box and count accumulators, advanced only by pixels belonging to a frame
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            accXMin  <= '1;
            accXMax  <= '0;
            accYMin  <= '1;
            accYMax  <= '0;
            accCount <= '0;
        end else if (framePix) begin
            accXMin  <= nextXMin;
            accXMax  <= nextXMax;
            accYMin  <= nextYMin;
            accYMax  <= nextYMax;
            accCount <= nextCount;
        end
    end

    // Per-pixel qualifier and mask, one cycle behind the input
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            oValid <= 1'b0;
            oMask  <= 1'b0;
        end else begin
            oValid <= iValid;
            oMask  <= iValid && pixMatch;
        end
    end

    // Publish the finished frame during the report cycle and hold until the next one
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            oFrameDone <= 1'b0;
            oFound     <= 1'b0;
            oCount     <= '0;
            oXMin      <= '0;
            oXMax      <= '0;
            oYMin      <= '0;
            oYMax      <= '0;
        end else begin
            oFrameDone <= 1'b0;
            if (state == REPORT) begin
                oFrameDone <= 1'b1;
                oFound     <= accAny;
                oCount     <= accCount;
                oXMin      <= accAny ? accXMin : '0;
                oXMax      <= accAny ? accXMax : '0;
                oYMin      <= accAny ? accYMin : '0;
                oYMax      <= accAny ? accYMax : '0;
            end
        end
    end

`ifdef HSL_TRACK_CENTROID_EN
    logic [SUM_W-1:0] accSumX;
    logic [SUM_W-1:0] accSumY;

    // Coordinate sums of matched pixels, restarted at each frame start
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            accSumX <= '0;
            accSumY <= '0;
        end else if (framePix) begin
            accSumX <= (sofPix ? '0 : accSumX) + (pixMatch ? SUM_W'(pixX) : '0);
            accSumY <= (sofPix ? '0 : accSumY) + (pixMatch ? SUM_W'(pixY) : '0);
        end
    end

    // Publish the sums alongside the box in the report cycle
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            oSumX <= '0;
            oSumY <= '0;
        end else if (state == REPORT) begin
            oSumX <= accSumX;
            oSumY <= accSumY;
        end
    end
`else
    assign oSumX = '0;
    assign oSumY = '0;
`endif

endmodule

// File: tb/tb_hsl_color_tracker.sv
// Testbench for hsl_color_tracker on a 4x2 frame: a frame-level model
// predicts every output each cycle, and directed vectors pin the model
// with hand-computed masks and frame results.
module tb_hsl_color_tracker;

    localparam int W = 4;
    localparam int H = 2;

    logic        clock;
    logic        reset_n;
    logic        iValid;
    logic        iSOF;
    logic [9:0]  iHue, iSat, iLight;
    logic [9:0]  iHueLo, iHueHi, iSatMin, iLightMin, iLightMax;
    logic        oValid, oMask, oFound, oFrameDone;
    logic [9:0]  oXMin, oXMax, oYMin, oYMax;
    logic [18:0] oCount;
    logic [27:0] oSumX, oSumY;

    int checks = 0;
    int errors = 0;
    int doneCount = 0;
    int doneBefore;
    bit cmpEn = 0;

    // model state
    int shLo, shHi, shSat, shLMin, shLMax;
    bit inFrame, pending;
    int idx;
    int aCount, aXMin, aXMax, aYMin, aYMax, aSumX, aSumY;
    int mValid, mMask, mDone, mFound, mCount, mXMin, mXMax, mYMin, mYMax, mSumX, mSumY;

    int hues1[8] = '{99, 100, 200, 201, 0, 0, 0, 0};
    int exp1[8]  = '{0, 1, 1, 0, 0, 0, 0, 0};
    int hues2[8] = '{767, 0, 50, 51, 699, 800, 300, 300};
    int exp2[8]  = '{1, 1, 1, 0, 0, 1, 0, 0};
    int sat6[8]  = '{49, 50, 50, 50, 50, 50, 100, 1023};
    int lit6[8]  = '{500, 500, 19, 20, 900, 901, 500, 600};
    int hue6[8]  = '{160, 160, 160, 160, 160, 160, 1023, 150};
    int exp6[8]  = '{0, 1, 0, 1, 1, 0, 0, 1};

    hsl_color_tracker #(.IMG_W(W), .IMG_H(H)) dut (
        .clock(clock), .reset_n(reset_n), .iValid(iValid), .iSOF(iSOF),
        .iHue(iHue), .iSat(iSat), .iLight(iLight),
        .iHueLo(iHueLo), .iHueHi(iHueHi), .iSatMin(iSatMin),
        .iLightMin(iLightMin), .iLightMax(iLightMax),
        .oValid(oValid), .oMask(oMask),
        .oXMin(oXMin), .oXMax(oXMax), .oYMin(oYMin), .oYMax(oYMax),
        .oCount(oCount), .oFound(oFound), .oFrameDone(oFrameDone),
        .oSumX(oSumX), .oSumY(oSumY)
    );

    // free-running clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int windowMatch(int h, int s, int l, int lo, int hi,
                                       int smin, int lmin, int lmax);
        int hh;
        bit hueOk;
        hh = (h >= 768) ? 0 : h;
        if (lo <= hi) hueOk = (hh >= lo) && (hh <= hi);
        else          hueOk = (hh >= lo) || (hh <= hi);
        return (hueOk && s >= smin && l >= lmin && l <= lmax) ? 1 : 0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // frame-level model: predicts outputs as seen after each rising edge
    always @(posedge clock) begin
        if (!reset_n) begin
            shLo = 0; shHi = 0; shSat = 0; shLMin = 0; shLMax = 0;
            inFrame = 0; pending = 0; idx = 0;
            mValid = 0; mMask = 0; mDone = 0; mFound = 0; mCount = 0;
            mXMin = 0; mXMax = 0; mYMin = 0; mYMax = 0; mSumX = 0; mSumY = 0;
        end else begin
            mDone = 0;
            if (pending) begin
                pending = 0;
                mDone   = 1;
                mFound  = (aCount > 0);
                mCount  = aCount;
                mXMin   = mFound ? aXMin : 0;
                mXMax   = mFound ? aXMax : 0;
                mYMin   = mFound ? aYMin : 0;
                mYMax   = mFound ? aYMax : 0;
`ifdef HSL_TRACK_CENTROID_EN
                mSumX   = aSumX;
                mSumY   = aSumY;
`else
                mSumX   = 0;
                mSumY   = 0;
`endif
            end
            if (iValid && iSOF) begin
                shLo = iHueLo; shHi = iHueHi; shSat = iSatMin;
                shLMin = iLightMin; shLMax = iLightMax;
                inFrame = 1; idx = 0;
                aCount = 0; aXMin = 1023; aXMax = 0; aYMin = 1023; aYMax = 0;
                aSumX = 0; aSumY = 0;
            end
            mValid = iValid;
            mMask  = iValid ? windowMatch(iHue, iSat, iLight, shLo, shHi, shSat, shLMin, shLMax) : 0;
            if (iValid && inFrame) begin
                if (mMask == 1) begin
                    int x, y;
                    x = idx % W;
                    y = idx / W;
                    aCount++;
                    if (x < aXMin) aXMin = x;
                    if (x > aXMax) aXMax = x;
                    if (y < aYMin) aYMin = y;
                    if (y > aYMax) aYMax = y;
                    aSumX += x;
                    aSumY += y;
                end
                idx++;
                if (idx == W * H) begin
                    inFrame = 0;
                    pending = 1;
                end
            end
        end
    end

    // compare every output with the model, away from the active edge
    always @(negedge clock) begin
        if (cmpEn) begin
            checkOutput("oValid", oValid, mValid);
            checkOutput("oMask", oMask, mMask);
            checkOutput("oFrameDone", oFrameDone, mDone);
            checkOutput("oFound", oFound, mFound);
            checkOutput("oCount", oCount, mCount);
            checkOutput("oXMin", oXMin, mXMin);
            checkOutput("oXMax", oXMax, mXMax);
            checkOutput("oYMin", oYMin, mYMin);
            checkOutput("oYMax", oYMax, mYMax);
            checkOutput("oSumX", oSumX, mSumX);
            checkOutput("oSumY", oSumY, mSumY);
        end
    end

    // count report strobes
    always @(negedge clock) begin
        if (oFrameDone === 1'b1) doneCount++;
    end

    task automatic setThresh(input int lo, input int hi, input int smin, input int lmin, input int lmax);
        iHueLo = lo[9:0]; iHueHi = hi[9:0]; iSatMin = smin[9:0];
        iLightMin = lmin[9:0]; iLightMax = lmax[9:0];
    endtask

    task automatic applyStimulus(input bit v, input bit sof, input int h, input int s, input int l);
        iValid = v; iSOF = sof;
        iHue = h[9:0]; iSat = s[9:0]; iLight = l[9:0];
        @(negedge clock);
    endtask

    task automatic idleCycles(input int n);
        iValid = 1'b0; iSOF = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    initial begin
        reset_n = 1'b0;
        iValid = 1'b0; iSOF = 1'b0; iHue = '0; iSat = '0; iLight = '0;
        setThresh(0, 0, 0, 0, 0);
        @(negedge clock);
        cmpEn = 1;
        @(negedge clock);
        checkOutput("resetValid", oValid, 0);
        checkOutput("resetDone", oFrameDone, 0);
        checkOutput("resetCount", oCount, 0);
        checkOutput("resetXMin", oXMin, 0);
        reset_n = 1'b1;

        // basic window, first frame
        setThresh(100, 200, 0, 0, 1023);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, i == 0, hues1[i], 0, 500);
            checkOutput($sformatf("basicMask%0d", i), oMask, exp1[i]);
        end
        idleCycles(3);
        checkOutput("basicDone", doneCount, 1);
        checkOutput("basicCount", oCount, 2);
        checkOutput("basicXMin", oXMin, 1);
        checkOutput("basicXMax", oXMax, 2);

        // wrapped window, immediately followed by a frame starting in the report cycle
        setThresh(700, 50, 0, 0, 1023);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, i == 0, hues2[i], 10, 10);
            checkOutput($sformatf("wrapMask%0d", i), oMask, exp2[i]);
            if (i == 7) setThresh(100, 200, 0, 0, 1023);
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, i == 0, (i == 1 || i == 7) ? 150 : 0, 10, 10);
        end
        idleCycles(3);
        checkOutput("boxDone", doneCount, 3);
        checkOutput("boxFound", oFound, 1);
        checkOutput("boxXMin", oXMin, 1);
        checkOutput("boxXMax", oXMax, 3);
        checkOutput("boxYMin", oYMin, 0);
        checkOutput("boxYMax", oYMax, 1);
        checkOutput("boxCount", oCount, 2);
`ifdef HSL_TRACK_CENTROID_EN
        checkOutput("boxSumX", oSumX, 4);
        checkOutput("boxSumY", oSumY, 1);
`else
        checkOutput("boxSumX", oSumX, 0);
        checkOutput("boxSumY", oSumY, 0);
`endif

        // partial frame discarded by a new SOF, then an empty full frame
        for (int i = 0; i < 3; i++) applyStimulus(1, i == 0, 150, 10, 10);
        for (int i = 0; i < 8; i++) applyStimulus(1, i == 0, 0, 10, 10);
        idleCycles(3);
        checkOutput("restartDone", doneCount, 4);
        checkOutput("emptyFound", oFound, 0);
        checkOutput("emptyCount", oCount, 0);
        checkOutput("emptyXMin", oXMin, 0);
        checkOutput("emptyYMax", oYMax, 0);
        checkOutput("emptySumX", oSumX, 0);

        // mid-frame threshold change waits for the next SOF
        applyStimulus(1, 1, 120, 10, 10);
        applyStimulus(1, 0, 120, 10, 10);
        setThresh(150, 200, 0, 0, 1023);
        applyStimulus(1, 0, 120, 10, 10);
        checkOutput("midChangeMask", oMask, 1);
        for (int i = 3; i < 8; i++) applyStimulus(1, 0, 120, 10, 10);
        idleCycles(2);
        checkOutput("fullCount", oCount, 8);
        checkOutput("fullXMax", oXMax, 3);
        applyStimulus(1, 1, 120, 10, 10);
        checkOutput("newLoMask", oMask, 0);
        applyStimulus(1, 0, 160, 10, 10);
        checkOutput("newLoMatch", oMask, 1);
        for (int i = 2; i < 8; i++) applyStimulus(1, 0, 0, 10, 10);
        idleCycles(2);

        // saturation and lightness limits, inclusive
        setThresh(150, 200, 50, 20, 900);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, i == 0, hue6[i], sat6[i], lit6[i]);
            checkOutput($sformatf("limitMask%0d", i), oMask, exp6[i]);
        end
        idleCycles(3);
        checkOutput("limitDone", doneCount, 7);
        checkOutput("limitCount", oCount, 4);

        // reset in the middle of a frame
        setThresh(100, 200, 0, 0, 1023);
        for (int i = 0; i < 3; i++) applyStimulus(1, i == 0, 150, 10, 10);
        doneBefore = doneCount;
        reset_n = 1'b0;
        idleCycles(1);
        checkOutput("midResetValid", oValid, 0);
        checkOutput("midResetCount", oCount, 0);
        checkOutput("midResetFound", oFound, 0);
        checkOutput("midResetXMax", oXMax, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 150, 10, 10);
        idleCycles(3);
        checkOutput("noDoneAfterReset", doneCount - doneBefore, 0);
        for (int i = 0; i < 8; i++) applyStimulus(1, i == 0, (i == 0) ? 150 : 0, 10, 10);
        idleCycles(3);
        checkOutput("doneAfterReset", doneCount - doneBefore, 1);
        checkOutput("afterResetCount", oCount, 1);
        checkOutput("afterResetFound", oFound, 1);

        cmpEn = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
